// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and port-index constants for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-input picker: round-robin or fixed priority (port 0 first)
module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On conflict, round-robin hands the win to whoever did not go last.
            2'b11:   gnt = (rr_en && (last == PORT0)) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-RAM arbiter, one access per IDLE/ACCESS/CAPTURE pass
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic RR_EN = 1'b1,
    parameter int   AW    = 10
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic [31:0]   m0_rdata,
    output logic          m0_ready,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic [31:0]   m1_rdata,
    output logic          m1_ready,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    output logic          ram_we,
    input  logic [31:0]   ram_dout,
    output logic          busy,
    output logic [1:0]    grant
);

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_grant;
    logic            r_last;
    logic            r_ram_we;
    logic [AW-1:0]   r_ram_addr;
    logic [31:0]     r_ram_din;
    logic [1:0]      w_gnt;
    logic            w_capture;

    // Byte-lane and out-of-range address bits are deliberately ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{m0_addr[1:0], m0_addr[31:AW+2], m1_addr[1:0], m1_addr[31:AW+2]};

    mem_arbiter_rr_arb2 u_arb (
        .req   ({m1_req, m0_req}),
        .last  (r_last),
        .rr_en (RR_EN),
        .gnt   (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (|w_gnt) w_next = ST_ACCESS;
            ST_ACCESS:  w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Payload is captured once at grant so requesters may move on immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_grant    <= 2'b00;
            r_last     <= PORT1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt[0]) begin
                        r_grant    <= 2'b01;
                        r_ram_we   <= m0_we;
                        r_ram_addr <= m0_addr[AW+1:2];
                        r_ram_din  <= m0_wdata;
                    end else if (w_gnt[1]) begin
                        r_grant    <= 2'b10;
                        r_ram_we   <= m1_we;
                        r_ram_addr <= m1_addr[AW+1:2];
                        r_ram_din  <= m1_wdata;
                    end
                end
                ST_ACCESS: r_ram_we <= 1'b0;
                ST_CAPTURE: begin
                    r_last  <= r_grant[1] ? PORT1 : PORT0;
                    r_grant <= 2'b00;
                end
                default: r_ram_we <= 1'b0;
            endcase
        end
    end

    assign w_capture = (r_state == ST_CAPTURE);
    assign m0_ready  = w_capture & r_grant[0];
    assign m1_ready  = w_capture & r_grant[1];
    assign m0_rdata  = m0_ready ? ram_dout : 32'h0;
    assign m1_rdata  = m1_ready ? ram_dout : 32'h0;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench: round-robin and fixed-priority arbiters on shared stimulus
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

    logic [31:0] m0_rdata_rr, m1_rdata_rr, ram_din_rr, ram_dout_rr;
    logic        m0_ready_rr, m1_ready_rr, ram_we_rr, busy_rr;
    logic [9:0]  ram_addr_rr;
    logic [1:0]  grant_rr;

    logic [31:0] m0_rdata_fp, m1_rdata_fp, ram_din_fp, ram_dout_fp;
    logic        m0_ready_fp, m1_ready_fp, ram_we_fp, busy_fp;
    logic [9:0]  ram_addr_fp;
    logic [1:0]  grant_fp;

    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] mem_rr [0:1023];
    logic [31:0] mem_fp [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    logic unused_fp;
    assign unused_fp = busy_fp;

    always #5 clk = ~clk;

    mem_arbiter #(.RR_EN(1'b1), .AW(10)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata_rr), .m0_ready(m0_ready_rr),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata_rr), .m1_ready(m1_ready_rr),
        .ram_addr(ram_addr_rr), .ram_din(ram_din_rr), .ram_we(ram_we_rr),
        .ram_dout(ram_dout_rr), .busy(busy_rr), .grant(grant_rr)
    );

    mem_arbiter #(.RR_EN(1'b0), .AW(10)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata_fp), .m0_ready(m0_ready_fp),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata_fp), .m1_ready(m1_ready_fp),
        .ram_addr(ram_addr_fp), .ram_din(ram_din_fp), .ram_we(ram_we_fp),
        .ram_dout(ram_dout_fp), .busy(busy_fp), .grant(grant_fp)
    );

    // Synchronous RAMs: read data appears the cycle after the address cycle.
    always @(posedge clk) begin
        if (pre_we) begin
            mem_rr[pre_addr] <= pre_data;
            mem_fp[pre_addr] <= pre_data;
        end else begin
            if (ram_we_rr) mem_rr[ram_addr_rr] <= ram_din_rr;
            if (ram_we_fp) mem_fp[ram_addr_fp] <= ram_din_fp;
        end
        ram_dout_rr <= mem_rr[ram_addr_rr];
        ram_dout_fp <= mem_fp[ram_addr_fp];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        tick();
        tick();
        check("rst_busy",    32'(busy_rr), 32'h0);
        check("rst_grant",   32'(grant_rr), 32'h0);
        check("rst_ram_we",  32'(ram_we_rr), 32'h0);
        check("rst_ram_addr", 32'(ram_addr_rr), 32'h0);
        check("rst_ram_din", ram_din_rr, 32'h0);
        check("rst_m0_ready", 32'(m0_ready_rr), 32'h0);
        check("rst_m1_ready", 32'(m1_ready_rr), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_busy",  32'(busy_rr), 32'h0);
        check("post_rst_rdata", m0_rdata_rr | m1_rdata_rr, 32'h0);
        check("idle_ram_we",    32'(ram_we_rr), 32'h0);

        pre_we = 1'b1; pre_addr = 10'd5; pre_data = 32'hDEADBEEF;
        tick();
        pre_we = 1'b0;

        // Single read of word 5
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h14;
        tick();
        check("rd_acc_busy",  32'(busy_rr), 32'h1);
        check("rd_acc_grant", 32'(grant_rr), 32'h1);
        check("rd_acc_addr",  32'(ram_addr_rr), 32'h5);
        check("rd_acc_ready", 32'(m0_ready_rr), 32'h0);
        tick();
        check("rd_cap_busy",  32'(busy_rr), 32'h1);
        check("rd_cap_ready", 32'(m0_ready_rr), 32'h1);
        check("rd_cap_rdata", m0_rdata_rr, 32'hDEADBEEF);
        check("rd_cap_m1rdy", 32'(m1_ready_rr), 32'h0);
        check("rd_cap_m1dat", m1_rdata_rr, 32'h0);
        m0_req = 1'b0;
        tick();
        check("rd_idle_busy",  32'(busy_rr), 32'h0);
        check("rd_idle_ready", 32'(m0_ready_rr), 32'h0);
        check("rd_idle_grant", 32'(grant_rr), 32'h0);

        // Upper and byte-lane address bits ignored: 0xFFFFF017 -> word 5
        m0_req = 1'b1; m0_addr = 32'hFFFF_F017;
        tick();
        check("hi_addr", 32'(ram_addr_rr), 32'h5);
        tick();
        check("hi_rdata", m0_rdata_rr, 32'hDEADBEEF);
        m0_req = 1'b0;
        tick();

        // m1 write then read of word 16
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h12345678;
        tick();
        check("wr_acc_we",    32'(ram_we_rr), 32'h1);
        check("wr_acc_addr",  32'(ram_addr_rr), 32'h10);
        check("wr_acc_din",   ram_din_rr, 32'h12345678);
        check("wr_acc_grant", 32'(grant_rr), 32'h2);
        m1_we = 1'b0;
        tick();
        check("wr_cap_we",    32'(ram_we_rr), 32'h0);
        check("wr_cap_ready", 32'(m1_ready_rr), 32'h1);
        check("wr_cap_m0rdy", 32'(m0_ready_rr), 32'h0);
        tick();
        check("wr_idle_we",   32'(ram_we_rr), 32'h0);
        check("wr_idle_busy", 32'(busy_rr), 32'h0);
        tick();
        check("rb_acc_we",    32'(ram_we_rr), 32'h0);
        check("rb_acc_grant", 32'(grant_rr), 32'h2);
        tick();
        check("rb_cap_rdata", m1_rdata_rr, 32'h12345678);
        m1_req = 1'b0;
        tick();

        // Contention: round-robin alternates from m0; fixed priority keeps m0
        m0_req = 1'b1; m0_addr = 32'h14; m1_req = 1'b1; m1_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check("rr_grant", 32'(grant_rr), 32'(exp_g));
            check("fp_grant", 32'(grant_fp), 32'h1);
            tick();
            check("rr_m0_ready", 32'(m0_ready_rr), 32'(exp_g[0]));
            check("rr_m1_ready", 32'(m1_ready_rr), 32'(exp_g[1]));
            check("rr_rdata", exp_g[0] ? m0_rdata_rr : m1_rdata_rr,
                  exp_g[0] ? 32'hDEADBEEF : 32'h12345678);
            check("fp_m0_ready", 32'(m0_ready_fp), 32'h1);
            check("fp_m0_rdata", m0_rdata_fp, 32'hDEADBEEF);
            check("fp_m1_ready", 32'(m1_ready_fp), 32'h0);
            check("fp_m1_rdata", m1_rdata_fp, 32'h0);
            tick();
            check("cont_idle_busy", 32'(busy_rr), 32'h0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Payload latched at grant: address change during ACCESS is ignored
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        tick();
        m0_addr = 32'h20;
        check("latch_acc_addr", 32'(ram_addr_rr), 32'h4);
        tick();
        check("latch_cap_addr",  32'(ram_addr_rr), 32'h4);
        check("latch_cap_ready", 32'(m0_ready_rr), 32'h1);
        m0_req = 1'b0;
        tick();

        // Reset during a write in ACCESS aborts it
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h08; m0_wdata = 32'hAAAA5555;
        tick();
        check("rstw_acc_we", 32'(ram_we_rr), 32'h1);
        rst = 1'b1;
        tick();
        check("rstw_busy",  32'(busy_rr), 32'h0);
        check("rstw_we",    32'(ram_we_rr), 32'h0);
        check("rstw_ready", 32'(m0_ready_rr), 32'h0);
        check("rstw_grant", 32'(grant_rr), 32'h0);
        rst = 1'b0; m0_req = 1'b0; m0_we = 1'b0;
        tick();
        check("rstw_post_ready", 32'(m0_ready_rr), 32'h0);
        check("rstw_post_busy",  32'(busy_rr), 32'h0);

        // Reset restores last_grant to port 1, so m0 wins the next conflict
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        check("rst_last_grant", 32'(grant_rr), 32'h1);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
